// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NUM_REQ requesters.
// Accepted requests are registered onto the RAM port, one per cycle. Reads are
// tracked through a latency-matched (valid, id) shift register, so every read
// result leaves tagged with the index of the requester that issued it.
module bram_rr_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  RAM_WIDTH  = 32,
   parameter int  RAM_DEPTH  = 512,
   parameter int  RD_LATENCY = 2,
   localparam int ADDR_W     = $clog2(RAM_DEPTH),
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*RAM_WIDTH-1:0]  req_wdata,
   output logic                          rsp_valid,
   output logic [ID_W-1:0]               rsp_id,
   output logic [RAM_WIDTH-1:0]          rsp_data,
   output logic                          ram_en,
   output logic                          ram_we,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [RAM_WIDTH-1:0]          ram_din,
   output logic                          ram_regce,
   input  logic [RAM_WIDTH-1:0]          ram_dout
);

   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      ptr_next;
   logic                 gnt_any;
   logic [ID_W-1:0]      gnt_idx;
   logic                 accept;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [RAM_WIDTH-1:0] sel_din;

   logic                 iss_rd_p0;
   logic [ID_W-1:0]      iss_id_p0;

   logic [RD_LATENCY-1:0] trk_vld_p;
   logic [ID_W-1:0]       trk_id_p [RD_LATENCY];

   // Scan from ptr upwards (mod NUM_REQ); iterating downwards lets the nearest index win
   always_comb begin
      int              j;
      logic [ID_W-1:0] idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      j       = 0;
      idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         idx = ID_W'(j);
         if (req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign accept   = gnt_any & ~rst;
   assign ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   // One-hot ready for the granted requester, muted while reset is held
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Route the granted requester's command fields to the issue stage
   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_din  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == ID_W'(i)) begin
            sel_we   = req_we[i];
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_din  = req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
         end
      end
   end

   // Issue stage (p0): drive the RAM port and advance the priority pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         iss_rd_p0 <= 1'b0;
         iss_id_p0 <= '0;
      end else begin
         ram_en    <= accept;
         ram_we    <= accept & sel_we;
         iss_rd_p0 <= accept & ~sel_we;
         if (accept) begin
            ptr       <= ptr_next;
            ram_addr  <= sel_addr;
            ram_din   <= sel_din;
            iss_id_p0 <= gnt_idx;
         end
      end
   end

   // Read tracking: (valid, id) follows each issued read through the RAM latency
   always_ff @(posedge clk) begin
      if (rst) begin
         trk_vld_p <= '0;
         for (int s = 0; s < RD_LATENCY; s++) begin
            trk_id_p[s] <= '0;
         end
      end else begin
         trk_vld_p[0] <= iss_rd_p0;
         trk_id_p[0]  <= iss_id_p0;
         for (int s = 1; s < RD_LATENCY; s++) begin
            trk_vld_p[s] <= trk_vld_p[s-1];
            trk_id_p[s]  <= trk_id_p[s-1];
         end
      end
   end

   assign rsp_valid = trk_vld_p[RD_LATENCY-1];
   assign rsp_id    = trk_id_p[RD_LATENCY-1];
   assign rsp_data  = ram_dout;

   // The output register only needs a clock enable while a read is moving through it
   generate
      if (RD_LATENCY == 2) begin : g_oreg
         assign ram_regce = trk_vld_p[0];
      end else begin : g_no_oreg
         assign ram_regce = 1'b1;
      end
   endgenerate

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Directed bench for bram_rr_arbiter with a behavioural BRAM port model
// (registered read, output register gated by ram_regce, RD_LATENCY = 2).
module tb_bram_rr_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 9;
   localparam int DW   = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NREQ-1:0]  req_valid = '0;
   logic [NREQ-1:0]  req_ready;
   logic [NREQ-1:0]  req_we = '0;
   logic [AW-1:0]    a [NREQ];
   logic [DW-1:0]    d [NREQ];
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic             rsp_valid;
   logic [1:0]       rsp_id;
   logic [DW-1:0]    rsp_data;
   logic             ram_en, ram_we, ram_regce;
   logic [AW-1:0]    ram_addr;
   logic [DW-1:0]    ram_din, ram_dout;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   // response log
   int            q_cyc [$];
   logic [1:0]    q_id  [$];
   logic [DW-1:0] q_dat [$];

   assign req_addr  = {a[3], a[2], a[1], a[0]};
   assign req_wdata = {d[3], d[2], d[1], d[0]};

   bram_rr_arbiter #(
      .NUM_REQ(NREQ), .RAM_WIDTH(DW), .RAM_DEPTH(512), .RD_LATENCY(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_regce(ram_regce), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: unwritten words read back as C0DE0000 | addr
   logic [DW-1:0]  mem [512];
   logic [511:0]   wr_seen;
   logic [DW-1:0]  ram_lat, ram_oreg;

   always @(posedge clk) begin
      if (rst) wr_seen <= '0;
      else if (ram_en && ram_we) wr_seen[ram_addr] <= 1'b1;
   end

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else ram_lat <= wr_seen[ram_addr] ? mem[ram_addr] : (32'hC0DE0000 | 32'(ram_addr));
      end
   end

   always @(posedge clk) if (ram_regce) ram_oreg <= ram_lat;
   assign ram_dout = ram_oreg;

   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         q_cyc.push_back(cyc);
         q_id.push_back(rsp_id);
         q_dat.push_back(rsp_data);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         req_valid = '0;
         req_we    = '0;
      end
   endtask

   task automatic clear_log();
      #1;
      q_cyc.delete();
      q_id.delete();
      q_dat.delete();
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         rst = 1'b1; req_valid = 4'hF; req_we = '0;
         #1;
         total++;
         if (req_ready !== 4'b0000) $display("FAIL reset_ready[%0d]: got %b want 0000", c, req_ready);
         else passed++;
         total++;
         if (ram_en !== 1'b0) $display("FAIL reset_ram_en[%0d]: got %b want 0", c, ram_en);
         else passed++;
         total++;
         if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid[%0d]: got %b want 0", c, rsp_valid);
         else passed++;
         total++;
         if (ram_addr !== 9'd0) $display("FAIL reset_ram_addr[%0d]: got %h want 000", c, ram_addr);
         else passed++;
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", req_ready);
      else passed++;
      @(negedge clk);
      req_valid = '0;
      #1;
      total++;
      if (ram_en !== 1'b1 || ram_we !== 1'b0) $display("FAIL reset_first_issue: got en=%b we=%b want en=1 we=0", ram_en, ram_we);
      else passed++;
   endtask

   task automatic test_single_read();
      int acc;
      idle(5);
      clear_log();
      @(negedge clk);
      req_valid = 4'b0100; req_we = 4'b0100; a[2] = 9'd5; d[2] = 32'hDEADBEEF;
      #1;
      total++;
      if (req_ready !== 4'b0100) $display("FAIL single_wr_grant: got %b want 0100", req_ready);
      else passed++;
      @(negedge clk);
      req_we = 4'b0000;
      #1;
      acc = cyc;
      total++;
      if (req_ready !== 4'b0100) $display("FAIL single_rd_grant: got %b want 0100", req_ready);
      else passed++;
      total++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 9'd5 || ram_din !== 32'hDEADBEEF)
         $display("FAIL single_wr_issue: got en=%b we=%b addr=%h din=%h want 1 1 005 deadbeef",
                  ram_en, ram_we, ram_addr, ram_din);
      else passed++;
      @(negedge clk);
      req_valid = '0;
      #1;
      total++;
      if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 9'd5)
         $display("FAIL single_rd_issue: got en=%b we=%b addr=%h want 1 0 005", ram_en, ram_we, ram_addr);
      else passed++;
      idle(6);
      total++;
      if (q_cyc.size() != 1) $display("FAIL single_rsp_count: got %0d want 1", q_cyc.size());
      else passed++;
      total++;
      if (q_cyc.size() == 0 || q_cyc[0] != acc + 3)
         $display("FAIL single_rsp_latency: got cycle %0d want %0d", (q_cyc.size() > 0) ? q_cyc[0] : -1, acc + 3);
      else passed++;
      total++;
      if (q_id.size() == 0 || q_id[0] !== 2'd2 || q_dat[0] !== 32'hDEADBEEF)
         $display("FAIL single_rsp_payload: got id=%0d data=%h want id=2 data=deadbeef",
                  (q_id.size() > 0) ? q_id[0] : 2'd0, (q_dat.size() > 0) ? q_dat[0] : 32'h0);
      else passed++;
   endtask

   task automatic test_round_robin();
      int acc0;
      logic [3:0] exp_rdy;
      @(negedge clk); rst = 1'b1; req_valid = '0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      clear_log();
      acc0 = 0;
      for (int i = 0; i < NREQ; i++) a[i] = 9'(10 + i);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_valid = 4'hF; req_we = '0;
         #1;
         if (k == 0) acc0 = cyc;
         exp_rdy = 4'(1 << (k % 4));
         total++;
         if (req_ready !== exp_rdy) $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy);
         else passed++;
      end
      idle(7);
      total++;
      if (q_cyc.size() != 5) $display("FAIL rr_rsp_count: got %0d want 5", q_cyc.size());
      else passed++;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (k >= q_cyc.size() || q_cyc[k] != acc0 + 3 + k || q_id[k] !== 2'(k % 4) ||
             q_dat[k] !== 32'hC0DE0000 + 32'(10 + (k % 4)))
            $display("FAIL rr_rsp[%0d]: got cyc=%0d id=%0d data=%h want cyc=%0d id=%0d data=%h", k,
                     (k < q_cyc.size()) ? q_cyc[k] : -1, (k < q_id.size()) ? q_id[k] : 2'd0,
                     (k < q_dat.size()) ? q_dat[k] : 32'h0, acc0 + 3 + k, k % 4,
                     32'hC0DE0000 + 32'(10 + (k % 4)));
         else passed++;
      end
   endtask

   task automatic test_ptr_continuation();
      @(negedge clk);
      req_valid = 4'b1000; req_we = '0;
      #1;
      total++;
      if (req_ready !== 4'b1000) $display("FAIL cont_solo3: got %b want 1000", req_ready);
      else passed++;
      @(negedge clk);
      req_valid = 4'b0101;
      #1;
      total++;
      if (req_ready !== 4'b0001) $display("FAIL cont_wrap0: got %b want 0001", req_ready);
      else passed++;
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      total++;
      if (req_ready !== 4'b0100) $display("FAIL cont_then2: got %b want 0100", req_ready);
      else passed++;
      idle(6);
   endtask

   task automatic test_back_to_back();
      int acc;
      clear_log();
      @(negedge clk);
      req_valid = 4'b0010; req_we = 4'b0010; a[1] = 9'd7; d[1] = 32'h00001234;
      #1;
      total++;
      if (req_ready !== 4'b0010) $display("FAIL b2b_wr_grant: got %b want 0010", req_ready);
      else passed++;
      @(negedge clk);
      req_valid = 4'b0100; req_we = 4'b0000; a[2] = 9'd7;
      #1;
      acc = cyc;
      total++;
      if (req_ready !== 4'b0100) $display("FAIL b2b_rd_grant: got %b want 0100", req_ready);
      else passed++;
      idle(7);
      total++;
      if (q_cyc.size() != 1 || q_cyc[0] != acc + 3 || q_id[0] !== 2'd2 || q_dat[0] !== 32'h00001234)
         $display("FAIL b2b_rsp: got n=%0d cyc=%0d id=%0d data=%h want n=1 cyc=%0d id=2 data=00001234",
                  q_cyc.size(), (q_cyc.size() > 0) ? q_cyc[0] : -1, (q_id.size() > 0) ? q_id[0] : 2'd0,
                  (q_dat.size() > 0) ? q_dat[0] : 32'h0, acc + 3);
      else passed++;
   endtask

   task automatic test_reset_midflight();
      clear_log();
      @(negedge clk);
      req_valid = 4'b0011; req_we = '0; a[0] = 9'd10; a[1] = 9'd11;
      #1;
      total++;
      if (req_ready !== 4'b0001) $display("FAIL mf_rd0_grant: got %b want 0001", req_ready);
      else passed++;
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      total++;
      if (req_ready !== 4'b0010) $display("FAIL mf_rd1_grant: got %b want 0010", req_ready);
      else passed++;
      @(negedge clk);
      rst = 1'b1; req_valid = 4'hF;
      #1;
      total++;
      if (req_ready !== 4'b0000) $display("FAIL mf_ready_in_rst: got %b want 0000", req_ready);
      else passed++;
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b0 || ram_en !== 1'b0) $display("FAIL mf_cleared: got rsp_valid=%b ram_en=%b want 0 0", rsp_valid, ram_en);
      else passed++;
      @(negedge clk);
      rst = 1'b0; req_valid = '0;
      idle(6);
      total++;
      if (q_cyc.size() != 0) $display("FAIL mf_no_rsp: got %0d responses want 0", q_cyc.size());
      else passed++;
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      total++;
      if (req_ready !== 4'b0001) $display("FAIL mf_ptr_zero: got %b want 0001", req_ready);
      else passed++;
      idle(4);
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         a[i] = '0;
         d[i] = '0;
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_ptr_continuation();
      test_back_to_back();
      test_reset_midflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
